riscv_dmem_arb: RTL and testbench

Arbitrates the single data-memory port between two requesters.
- Port 0 is the EX-stage load/store unit.
- Port 1 is a secondary master (debug unit / page-table walker).
- The block sits between the requesters and the data cache/BIU. It applies fixed priority with starvation protection, honours locked (atomic) sequences, and tracks outstanding transactions so in-order acks are routed back to the issuing port.

---
 rtl/riscv_dmem_arb_if.sv | 61 ++++++
 rtl/riscv_dmem_arb.sv | 135 +++++++++++++
 tb/tb_riscv_dmem_arb.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_arb_if.sv
// Bundle of the two requester ports and the data-memory port seen by riscv_dmem_arb.
// The slave modport is the arbiter's view; the master modport drives requests and memory responses.
interface riscv_dmem_arb_if #(
    parameter int MXLEN = 32
);
    typedef logic [2:0] biu_size_t;

    logic             m0_req_i;
    logic             m0_lock_i;
    logic [MXLEN-1:0] m0_adr_i;
    biu_size_t        m0_size_i;
    logic             m0_we_i;
    logic [MXLEN-1:0] m0_d_i;
    logic             m0_gnt_o;
    logic             m0_ack_o;
    logic [MXLEN-1:0] m0_q_o;
    logic             m0_misaligned_o;
    logic             m0_page_fault_o;

    logic             m1_req_i;
    logic             m1_lock_i;
    logic [MXLEN-1:0] m1_adr_i;
    biu_size_t        m1_size_i;
    logic             m1_we_i;
    logic [MXLEN-1:0] m1_d_i;
    logic             m1_gnt_o;
    logic             m1_ack_o;
    logic [MXLEN-1:0] m1_q_o;
    logic             m1_misaligned_o;
    logic             m1_page_fault_o;

    logic             dmem_req_o;
    logic             dmem_lock_o;
    logic [MXLEN-1:0] dmem_adr_o;
    biu_size_t        dmem_size_o;
    logic             dmem_we_o;
    logic [MXLEN-1:0] dmem_d_o;
    logic             dmem_rdy_i;
    logic [MXLEN-1:0] dmem_q_i;
    logic             dmem_ack_i;
    logic             dmem_misaligned_i;
    logic             dmem_page_fault_i;

    modport slave (
        input  m0_req_i, m0_lock_i, m0_adr_i, m0_size_i, m0_we_i, m0_d_i,
        output m0_gnt_o, m0_ack_o, m0_q_o, m0_misaligned_o, m0_page_fault_o,
        input  m1_req_i, m1_lock_i, m1_adr_i, m1_size_i, m1_we_i, m1_d_i,
        output m1_gnt_o, m1_ack_o, m1_q_o, m1_misaligned_o, m1_page_fault_o,
        output dmem_req_o, dmem_lock_o, dmem_adr_o, dmem_size_o, dmem_we_o, dmem_d_o,
        input  dmem_rdy_i, dmem_q_i, dmem_ack_i, dmem_misaligned_i, dmem_page_fault_i
    );

    modport master (
        output m0_req_i, m0_lock_i, m0_adr_i, m0_size_i, m0_we_i, m0_d_i,
        input  m0_gnt_o, m0_ack_o, m0_q_o, m0_misaligned_o, m0_page_fault_o,
        output m1_req_i, m1_lock_i, m1_adr_i, m1_size_i, m1_we_i, m1_d_i,
        input  m1_gnt_o, m1_ack_o, m1_q_o, m1_misaligned_o, m1_page_fault_o,
        input  dmem_req_o, dmem_lock_o, dmem_adr_o, dmem_size_o, dmem_we_o, dmem_d_o,
        output dmem_rdy_i, dmem_q_i, dmem_ack_i, dmem_misaligned_i, dmem_page_fault_i
    );
endinterface

// File: rtl/riscv_dmem_arb.sv
// Two-port data-memory arbiter: fixed priority to port 0 with starvation relief for port 1,
// locked sequences, in-order ack routing. 0-cycle grant and ack; backpressure via dmem_rdy_i and MAX_PENDING.
module riscv_dmem_arb #(
    parameter int MXLEN        = 32,
    parameter int MAX_PENDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    riscv_dmem_arb_if.slave      bus
);
    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic [CW-1:0]          cnt_q;
    logic [PW-1:0]          wr_q, rd_q;
    logic [MAX_PENDING-1:0] id_q;

    logic             sel, slot_ok, sel_req, sel_lock, sel_we, accept, pop, empty, head;
    logic [MXLEN-1:0] sel_adr, sel_d;
    logic [2:0]       sel_size;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_PENDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign head    = id_q[rd_q];
    assign slot_ok = (cnt_q < CW'(MAX_PENDING)) | bus.dmem_ack_i;

    // Inside a locked sequence only the owner may be selected.
    always_comb begin
        sel = 1'b0;
        if (state_q == ST_LOCKED)
            sel = owner_q;
        else
            sel = bus.m1_req_i & (~bus.m0_req_i | (starve_q == SW'(STARVE_LIMIT)));
    end

    assign sel_req  = sel ? bus.m1_req_i  : bus.m0_req_i;
    assign sel_lock = sel ? bus.m1_lock_i : bus.m0_lock_i;
    assign sel_we   = sel ? bus.m1_we_i   : bus.m0_we_i;
    assign sel_adr  = sel ? bus.m1_adr_i  : bus.m0_adr_i;
    assign sel_d    = sel ? bus.m1_d_i    : bus.m0_d_i;
    assign sel_size = sel ? bus.m1_size_i : bus.m0_size_i;

    // Reset gating keeps every output quiet while rst_ni is low, even with live requests.
    assign bus.dmem_req_o  = rst_ni & sel_req & slot_ok;
    assign bus.dmem_lock_o = bus.dmem_req_o & sel_lock;
    assign bus.dmem_we_o   = bus.dmem_req_o & sel_we;
    assign bus.dmem_adr_o  = bus.dmem_req_o ? sel_adr  : '0;
    assign bus.dmem_d_o    = bus.dmem_req_o ? sel_d    : '0;
    assign bus.dmem_size_o = bus.dmem_req_o ? sel_size : '0;

    assign accept       = bus.dmem_req_o & bus.dmem_rdy_i;
    assign bus.m0_gnt_o = accept & ~sel;
    assign bus.m1_gnt_o = accept & sel;

    assign pop = rst_ni & bus.dmem_ack_i & ~empty;

    assign bus.m0_ack_o        = pop & ~head;
    assign bus.m1_ack_o        = pop & head;
    assign bus.m0_q_o          = bus.m0_ack_o ? bus.dmem_q_i : '0;
    assign bus.m1_q_o          = bus.m1_ack_o ? bus.dmem_q_i : '0;
    assign bus.m0_misaligned_o = bus.m0_ack_o & bus.dmem_misaligned_i;
    assign bus.m1_misaligned_o = bus.m1_ack_o & bus.dmem_misaligned_i;
    assign bus.m0_page_fault_o = bus.m0_ack_o & bus.dmem_page_fault_i;
    assign bus.m1_page_fault_o = bus.m1_ack_o & bus.dmem_page_fault_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_ARB: begin
                if (accept & sel_lock) begin
                    state_d = ST_LOCKED;
                    owner_d = sel;
                end
            end
            ST_LOCKED: begin
                if (~(owner_q ? bus.m1_lock_i : bus.m0_lock_i) & empty)
                    state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (~bus.m1_req_i | bus.m1_gnt_o)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_ARB;
            owner_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Issue-order ID FIFO; slot_ok guarantees a push into a full FIFO only alongside a pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (accept) begin
                id_q[wr_q] <= sel;
                wr_q       <= ptr_inc(wr_q);
            end
            if (pop)
                rd_q <= ptr_inc(rd_q);
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Bench for riscv_dmem_arb: directed scenarios then random traffic, all outputs compared each cycle
// against a queue-based reference model of the arbitration, lock and ack-routing rules.
module tb_riscv_dmem_arb;
    localparam int MXLEN = 32;
    localparam int MAXP  = 2;
    localparam int SL    = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    riscv_dmem_arb_if #(.MXLEN(MXLEN)) bus();

    riscv_dmem_arb #(.MXLEN(MXLEN), .MAX_PENDING(MAXP), .STARVE_LIMIT(SL)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // requester and memory stimulus
    logic             req [2];
    logic             lock[2];
    logic [MXLEN-1:0] adr [2];
    logic [2:0]       size[2];
    logic             we  [2];
    logic [MXLEN-1:0] d   [2];
    logic             rdy, mack, mmis, mpf;
    logic [MXLEN-1:0] mq;

    // reference model state
    int  idq[$];
    bit  locked;
    int  owner;
    int  starve;

    int  checks = 0;
    int  errors = 0;
    logic             g_gnt[2];
    logic             g_ack[2];
    logic             g_req;
    logic [MXLEN-1:0] g_adr;
    logic [MXLEN-1:0] g_q0;
    int  lrun[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.m0_req_i = req[0];  bus.m0_lock_i = lock[0]; bus.m0_adr_i = adr[0];
        bus.m0_size_i = size[0]; bus.m0_we_i = we[0];    bus.m0_d_i = d[0];
        bus.m1_req_i = req[1];  bus.m1_lock_i = lock[1]; bus.m1_adr_i = adr[1];
        bus.m1_size_i = size[1]; bus.m1_we_i = we[1];    bus.m1_d_i = d[1];
        bus.dmem_rdy_i = rdy; bus.dmem_ack_i = mack; bus.dmem_q_i = mq;
        bus.dmem_misaligned_i = mmis; bus.dmem_page_fault_i = mpf;
    endtask

    // One cycle: drive inputs, compare every output with the model, advance model across the edge.
    task automatic step();
        int pend, sel, head;
        bit slot, ereq, acc, ackv;
        bit eack[2];
        apply();
        #3;
        pend = idq.size();
        slot = (pend < MAXP) || mack;
        if (locked) sel = owner;
        else        sel = (req[1] && (!req[0] || starve == SL)) ? 1 : 0;
        ereq = rst_ni && req[sel] && slot;
        acc  = ereq && rdy;
        ackv = rst_ni && mack && (pend > 0);
        head = (pend > 0) ? idq[0] : 0;
        eack[0] = ackv && head == 0;
        eack[1] = ackv && head == 1;

        g_gnt[0] = bus.m0_gnt_o; g_gnt[1] = bus.m1_gnt_o;
        g_ack[0] = bus.m0_ack_o; g_ack[1] = bus.m1_ack_o;
        g_req = bus.dmem_req_o; g_adr = bus.dmem_adr_o; g_q0 = bus.m0_q_o;

        check("dmem_req",  64'(bus.dmem_req_o),  64'(ereq));
        check("dmem_adr",  64'(bus.dmem_adr_o),  ereq ? 64'(adr[sel])  : 64'd0);
        check("dmem_d",    64'(bus.dmem_d_o),    ereq ? 64'(d[sel])    : 64'd0);
        check("dmem_size", 64'(bus.dmem_size_o), ereq ? 64'(size[sel]) : 64'd0);
        check("dmem_we",   64'(bus.dmem_we_o),   ereq ? 64'(we[sel])   : 64'd0);
        check("dmem_lock", 64'(bus.dmem_lock_o), ereq ? 64'(lock[sel]) : 64'd0);
        check("m0_gnt", 64'(bus.m0_gnt_o), 64'(acc && sel == 0));
        check("m1_gnt", 64'(bus.m1_gnt_o), 64'(acc && sel == 1));
        check("m0_ack", 64'(bus.m0_ack_o), 64'(eack[0]));
        check("m1_ack", 64'(bus.m1_ack_o), 64'(eack[1]));
        check("m0_q",   64'(bus.m0_q_o),   eack[0] ? 64'(mq) : 64'd0);
        check("m1_q",   64'(bus.m1_q_o),   eack[1] ? 64'(mq) : 64'd0);
        check("m0_err", {62'd0, bus.m0_misaligned_o, bus.m0_page_fault_o},
              eack[0] ? {62'd0, mmis, mpf} : 64'd0);
        check("m1_err", {62'd0, bus.m1_misaligned_o, bus.m1_page_fault_o},
              eack[1] ? {62'd0, mmis, mpf} : 64'd0);

        if (!rst_ni) begin
            idq.delete(); locked = 0; owner = 0; starve = 0;
        end else begin
            if (ackv) void'(idq.pop_front());
            if (acc)  idq.push_back(sel);
            if (!locked) begin
                if (acc && lock[sel]) begin locked = 1; owner = sel; end
            end else if (!lock[owner] && pend == 0) begin
                locked = 0;
            end
            if (req[1] && !(acc && sel == 1)) starve = (starve < SL) ? starve + 1 : SL;
            else                              starve = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            req[n] = 0; lock[n] = 0; adr[n] = '0; size[n] = '0; we[n] = 0; d[n] = '0; lrun[n] = 0;
        end
        rdy = 0; mack = 0; mq = '0; mmis = 0; mpf = 0;
        locked = 0; owner = 0; starve = 0;
        step(); step();
        rst_ni = 1'b1;

        // 1: single read from port 0
        req[0] = 1; adr[0] = 32'h100; size[0] = 3'd2; rdy = 1;
        step();
        check("t1_gnt0", 64'(g_gnt[0]), 64'd1);
        check("t1_adr",  64'(g_adr), 64'h100);
        req[0] = 0; mack = 1; mq = 32'hDEADBEEF;
        step();
        check("t1_ack0", 64'(g_ack[0]), 64'd1);
        check("t1_q0",   64'(g_q0), 64'hDEADBEEF);
        check("t1_ack1", 64'(g_ack[1]), 64'd0);
        mack = 0;

        // 2: starvation relief
        req[0] = 1; req[1] = 1; adr[1] = 32'h200; d[1] = 32'h55; we[1] = 1;
        for (int i = 0; i < 8; i++) begin
            mack = (i > 0); mq = 32'h1000 + i;
            step();
            check("t2_gnt1", 64'(g_gnt[1]), 64'(i == 4));
            check("t2_gnt0", 64'(g_gnt[0]), 64'(i != 4));
        end
        req[0] = 0; req[1] = 0; mack = 1;
        step();
        mack = 0;

        // 3: pending limit, ack frees a slot in the same cycle
        req[0] = 1;
        step(); check("t3_g1", 64'(g_gnt[0]), 64'd1);
        step(); check("t3_g2", 64'(g_gnt[0]), 64'd1);
        step(); check("t3_full", 64'(g_req), 64'd0);
        mack = 1;
        step(); check("t3_g3", 64'(g_gnt[0]), 64'd1);
        mack = 0;
        step(); check("t3_still_full", 64'(g_req), 64'd0);
        req[0] = 0; mack = 1;
        step(); step();
        mack = 0;

        // 4: in-order ack routing, stray ack
        req[1] = 1; step(); check("t4_g1", 64'(g_gnt[1]), 64'd1);
        req[1] = 0; req[0] = 1; step(); check("t4_g0", 64'(g_gnt[0]), 64'd1);
        req[0] = 0; mack = 1;
        step(); check("t4_a1", 64'(g_ack[1]), 64'd1); check("t4_a1n", 64'(g_ack[0]), 64'd0);
        step(); check("t4_a0", 64'(g_ack[0]), 64'd1); check("t4_a0n", 64'(g_ack[1]), 64'd0);
        step(); check("t4_stray", {62'd0, g_ack[0], g_ack[1]}, 64'd0);
        mack = 0;

        // 5: locked sequence blocks port 1
        req[0] = 1; lock[0] = 1; req[1] = 1;
        step(); check("t5_lg", 64'(g_gnt[0]), 64'd1);
        mack = 1;
        for (int i = 0; i < 3; i++) begin
            step(); check("t5_blk", 64'(g_gnt[1]), 64'd0);
        end
        req[0] = 0;
        step(); check("t5_idle", 64'(g_gnt[1]), 64'd0);
        lock[0] = 0; mack = 0;
        step(); check("t5_exit", 64'(g_gnt[1]), 64'd0);
        step(); check("t5_m1", 64'(g_gnt[1]), 64'd1);
        req[1] = 0; mack = 1;
        step();
        mack = 0;

        // 6: reset while locked with two outstanding
        req[0] = 1; lock[0] = 1;
        step(); step();
        req[1] = 1;
        rst_ni = 1'b0;
        step(); check("t6_req", 64'(g_req), 64'd0); check("t6_gnt0", 64'(g_gnt[0]), 64'd0);
        step();
        rst_ni = 1'b1; req[0] = 0; lock[0] = 0; mack = 1;
        step();
        check("t6_gnt1", 64'(g_gnt[1]), 64'd1);
        check("t6_stray", {62'd0, g_ack[0], g_ack[1]}, 64'd0);
        req[1] = 0;
        step();
        mack = 0;
        step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (g_gnt[n]) begin
                    req[n] = 0;
                    if (lrun[n] > 0) lrun[n]--;
                    lock[n] = (lrun[n] > 0);
                end else if (!req[n] && $urandom_range(2) == 0) begin
                    if (lrun[n] == 0 && $urandom_range(7) == 0) lrun[n] = 1 + $urandom_range(2);
                    req[n]  = 1;
                    lock[n] = (lrun[n] > 0);
                    adr[n]  = $urandom; d[n] = $urandom;
                    size[n] = 3'($urandom_range(7)); we[n] = 1'($urandom_range(1));
                end
            end
            rdy  = ($urandom_range(3) != 0);
            mack = (idq.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
            mq   = $urandom; mmis = 1'($urandom_range(1)); mpf = 1'($urandom_range(1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
